// File: rtl/bp_clint_cmd_arbiter.sv
// Two-requester command arbiter in front of the CLINT with in-order response routing.
// Define BP_CLINT_ARB_FIXED_PRIO_EN to make requester 0 win ties (no round-robin).
module bp_clint_cmd_arbiter #(
  parameter int msg_width_p = 0,
  parameter int max_outstanding_p = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [msg_width_p-1:0] cmd0_i,
  input  logic                   cmd0_v_i,
  output logic                   cmd0_ready_o,
  input  logic [msg_width_p-1:0] cmd1_i,
  input  logic                   cmd1_v_i,
  output logic                   cmd1_ready_o,
  output logic [msg_width_p-1:0] cmd_o,
  output logic                   cmd_v_o,
  input  logic                   cmd_ready_i,
  input  logic [msg_width_p-1:0] resp_i,
  input  logic                   resp_v_i,
  output logic                   resp_yumi_o,
  output logic [msg_width_p-1:0] resp0_o,
  output logic                   resp0_v_o,
  input  logic                   resp0_yumi_i,
  output logic [msg_width_p-1:0] resp1_o,
  output logic                   resp1_v_o,
  input  logic                   resp1_yumi_i
);

  localparam int cnt_w = $clog2(max_outstanding_p + 1);
  localparam int ptr_w =
    (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(max_outstanding_p);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(max_outstanding_p - 1);

  logic [max_outstanding_p-1:0] tags;
  logic [ptr_w-1:0] head, tail;
  logic [cnt_w-1:0] count;
  logic lock_v, lock_id;
  logic grant, both_pick, issue_ok;
  logic xfer, pop, empty, head_tag;

`ifdef BP_CLINT_ARB_FIXED_PRIO_EN
  assign both_pick = 1'b0;
`else
  logic rr_ptr;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rr_ptr <= 1'b0;
    else if (xfer) rr_ptr <= ~grant;
  end

  assign both_pick = rr_ptr;
`endif

  assign issue_ok = reset_i & (count < max_cnt);
  assign empty = (count == '0);
  assign head_tag = tags[head];

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      lock_v: grant = lock_id;
      (!lock_v & cmd0_v_i & cmd1_v_i): grant = both_pick;
      (!lock_v & !cmd0_v_i & cmd1_v_i): grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign cmd_o = grant ? cmd1_i : cmd0_i;
  assign cmd_v_o = issue_ok & (grant ? cmd1_v_i : cmd0_v_i);
  assign cmd0_ready_o = issue_ok & cmd_ready_i & ~grant;
  assign cmd1_ready_o = issue_ok & cmd_ready_i & grant;
  assign xfer = cmd_v_o & cmd_ready_i;

  // Responses return in issue order, so the FIFO head names the owner.
  assign resp0_o = resp_i;
  assign resp1_o = resp_i;
  assign resp0_v_o = resp_v_i & ~empty & ~head_tag;
  assign resp1_v_o = resp_v_i & ~empty & head_tag;
  assign resp_yumi_o = (resp0_v_o & resp0_yumi_i)
                     | (resp1_v_o & resp1_yumi_i);
  assign pop = resp_yumi_o;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lock_v <= 1'b0;
      lock_id <= 1'b0;
    end else if (xfer) begin
      lock_v <= 1'b0;
    end else if (cmd_v_o) begin
      lock_v <= 1'b1;
      lock_id <= grant;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tags <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (xfer) begin
        tags[tail] <= grant;
        tail <= (tail == last_ptr) ? '0 : tail + 1'b1;
      end
      if (pop) head <= (head == last_ptr) ? '0 : head + 1'b1;
      if (xfer & ~pop) count <= count + 1'b1;
      else if (pop & ~xfer) count <= count - 1'b1;
    end
  end

`ifndef SYNTHESIS
  resp_while_empty: assert property (
    @(posedge clk_i) disable iff (!reset_i) !(resp_v_i && empty));
`endif

endmodule

// File: tb/tb_bp_clint_cmd_arbiter.sv
// Self-checking bench for bp_clint_cmd_arbiter: directed scenarios
// followed by a randomized phase against a queue-based reference model.
module tb_bp_clint_cmd_arbiter;

  localparam int W = 16;
  localparam int MAX = 2;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0, rdata = '0;
  logic v0 = 1'b0, v1 = 1'b0, crdy = 1'b0;
  logic rv = 1'b0, y0 = 1'b0, y1 = 1'b0;
  logic [W-1:0] cmd_o, resp0_o, resp1_o;
  logic cmd_v_o, cmd0_ready_o, cmd1_ready_o;
  logic resp_yumi_o, resp0_v_o, resp1_v_o;

  int checks = 0;
  int errors = 0;
  bit q[$];
  bit rr = 0, lk_v = 0, lk_id = 0;
  bit auto_mode = 0;

  always #5 clk_i = ~clk_i;

  bp_clint_cmd_arbiter #(
    .msg_width_p(W),
    .max_outstanding_p(MAX)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .cmd0_i(d0),
    .cmd0_v_i(v0),
    .cmd0_ready_o(cmd0_ready_o),
    .cmd1_i(d1),
    .cmd1_v_i(v1),
    .cmd1_ready_o(cmd1_ready_o),
    .cmd_o(cmd_o),
    .cmd_v_o(cmd_v_o),
    .cmd_ready_i(crdy),
    .resp_i(rdata),
    .resp_v_i(rv),
    .resp_yumi_o(resp_yumi_o),
    .resp0_o(resp0_o),
    .resp0_v_o(resp0_v_o),
    .resp0_yumi_i(y0),
    .resp1_o(resp1_o),
    .resp1_v_o(resp1_v_o),
    .resp1_yumi_i(y1)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict, compare at negedge+1, advance the model.
  task automatic step();
    bit g, iss, cv, tr, pp, hd;
    if (q.size() == 0) rv = 1'b0;
    iss = q.size() < MAX;
`ifdef BP_CLINT_ARB_FIXED_PRIO_EN
    g = lk_v ? lk_id : (v0 && v1) ? 1'b0 : v1;
`else
    g = lk_v ? lk_id : (v0 && v1) ? rr : v1;
`endif
    cv = iss && (g ? v1 : v0);
    hd = (q.size() > 0) ? q[0] : 1'b0;
    pp = rv && (hd ? y1 : y0);
    tr = cv && crdy;
    #1;
    chk("cmd_v", cmd_v_o, cv);
    if (cv) chk("cmd_o", cmd_o, g ? d1 : d0);
    if (v0 || v1 || lk_v) begin
      chk("ready0", cmd0_ready_o, iss && crdy && !g);
      chk("ready1", cmd1_ready_o, iss && crdy && g);
    end
    chk("resp0_v", resp0_v_o, rv && !hd);
    chk("resp1_v", resp1_v_o, rv && hd);
    chk("resp_yumi", resp_yumi_o, pp);
    if (rv) begin
      chk("resp0_data", resp0_o, rdata);
      chk("resp1_data", resp1_o, rdata);
    end
    @(posedge clk_i);
    if (pp) void'(q.pop_front());
    if (tr) begin
      q.push_back(g);
      rr = !g;
      lk_v = 0;
    end else if (cv) begin
      lk_v = 1;
      lk_id = g;
    end
    @(negedge clk_i);
    if (auto_mode) begin
      if ((tr && !g) || !v0) begin
        v0 = 1'($urandom % 2);
        d0 = W'($urandom);
      end
      if ((tr && g) || !v1) begin
        v1 = 1'($urandom % 2);
        d1 = W'($urandom);
      end
      crdy = ($urandom % 4) != 0;
      rv = (q.size() > 0) && ($urandom % 2 == 1);
      rdata = W'($urandom);
      y0 = 1'($urandom % 2);
      y1 = 1'($urandom % 2);
    end
  endtask

  task automatic drain();
    int guard = 0;
    v0 = 0;
    v1 = 0;
    while (q.size() > 0 && guard < 20) begin
      rv = 1;
      y0 = 1;
      y1 = 1;
      rdata = W'($urandom);
      step();
      guard++;
    end
    chk("drain_done", q.size(), 0);
    rv = 0;
  endtask

  initial begin
    // Reset state while both requesters are asking
    v0 = 1; v1 = 1; crdy = 1;
    #3;
    chk("rst_cmd_v", cmd_v_o, 0);
    chk("rst_ready0", cmd0_ready_o, 0);
    chk("rst_ready1", cmd1_ready_o, 0);
    chk("rst_yumi", resp_yumi_o, 0);
    chk("rst_resp0_v", resp0_v_o, 0);
    chk("rst_resp1_v", resp1_v_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1;
    v0 = 0; v1 = 0;

    // Requester 0 alone, three back-to-back writes, immediate yumi
    d0 = 16'h0b00;
    for (int i = 0; i < 3; i++) begin
      v0 = 1; y0 = 1; y1 = 1;
      rv = q.size() > 0;
      rdata = W'($urandom);
      step();
    end
    drain();

    // Both requesters continuously valid: grants alternate
    d0 = 16'h1111; d1 = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      v0 = 1; v1 = 1; y0 = 1; y1 = 1;
      rv = q.size() > 0;
      rdata = W'($urandom);
      step();
    end
    drain();

    // Fill to max with responses withheld, then release one
    v0 = 1; crdy = 1; rv = 0;
    for (int i = 0; i < 3; i++) step();
    rv = 1; y0 = 1; rdata = 16'hbeef;
    step();
    rv = 0;
    step();
    drain();

    // Offer held by requester 1 while CLINT stalls
    v1 = 1; d1 = 16'hd1d1; d0 = 16'hd0d0; crdy = 0;
    for (int i = 0; i < 4; i++) begin
      v0 = (i >= 1);
      step();
    end
    crdy = 1;
    step();
    v1 = 0;
    step();
    drain();

    // Response waits for yumi
    v0 = 1; crdy = 1;
    step();
    v0 = 0; rv = 1; y0 = 0; rdata = 16'h5a5a;
    for (int i = 0; i < 3; i++) step();
    y0 = 1;
    step();
    rv = 0;

    // Randomized traffic
    auto_mode = 1;
    for (int i = 0; i < 400; i++) step();
    auto_mode = 0;
    crdy = 1;
    drain();

    // Asynchronous reset with two tags outstanding
    v0 = 1; crdy = 1; rv = 0;
    step();
    step();
    #3;
    reset_i = 0;
    rv = 1;
    #1;
    chk("arst_cmd_v", cmd_v_o, 0);
    chk("arst_ready0", cmd0_ready_o, 0);
    chk("arst_yumi", resp_yumi_o, 0);
    chk("arst_resp0_v", resp0_v_o, 0);
    chk("arst_resp1_v", resp1_v_o, 0);
    q.delete();
    rr = 0; lk_v = 0; lk_id = 0;
    rv = 0;
    @(negedge clk_i);
    reset_i = 1;
    v0 = 1;
    step();
    step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
